// File: rtl/chdr_trigger_pulse_shaper_if.sv
// Trigger/configuration bundle between a trigger source and chdr_trigger_pulse_shaper.
// The master drives trigger and configuration; the slave (shaper) drives pulse and counters.
interface chdr_trigger_pulse_shaper_if #(
  parameter int DLY_W = 16,
  parameter int PW_W  = 16,
  parameter int CNT_W = 32
);
  logic             enable;
  logic             trigger_in;
  logic [DLY_W-1:0] delay;
  logic [PW_W-1:0]  width;
  logic [DLY_W-1:0] holdoff;
  logic             trigger_out;
  logic             busy;
  logic [CNT_W-1:0] event_count;
  logic [CNT_W-1:0] miss_count;

  modport master (
    output enable, trigger_in, delay, width, holdoff,
    input  trigger_out, busy, event_count, miss_count
  );

  modport slave (
    input  enable, trigger_in, delay, width, holdoff,
    output trigger_out, busy, event_count, miss_count
  );
endinterface

// File: rtl/chdr_trigger_pulse_shaper.sv
// Turns accepted header triggers into delayed fixed-width pulses with holdoff, counting events.
// Optional CHDR_TRIG_MISS_COUNT_EN builds a saturating counter of triggers dropped while busy.
module chdr_trigger_pulse_shaper #(
  parameter int DLY_W = 16,
  parameter int PW_W  = 16,
  parameter int CNT_W = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  chdr_trigger_pulse_shaper_if.slave   ifc
);

  localparam int CW = (DLY_W > PW_W) ? DLY_W : PW_W;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DELAY   = 2'd1;
  localparam logic [1:0] ST_ACTIVE  = 2'd2;
  localparam logic [1:0] ST_HOLDOFF = 2'd3;

  logic [1:0]       state_r, state_nx_s;
  logic [CW-1:0]    cnt_r, cnt_nx_s;
  logic [PW_W-1:0]  width_l_r, width_l_nx_s;
  logic [DLY_W-1:0] holdoff_l_r, holdoff_l_nx_s;
  logic             trigger_out_r, trig_nx_s;
  logic             busy_r;
  logic             accept_s;
  logic [CNT_W-1:0] event_count_r;

  // A zero width still produces a one-cycle pulse, so the counter load is max(w,1)-1.
  function automatic logic [CW-1:0] pulse_len_m1(input logic [PW_W-1:0] w);
    if (w == {PW_W{1'b0}}) begin
      return {CW{1'b0}};
    end else begin
      return CW'(w) - CW'(1);
    end
  endfunction

  // Next-state, counter and pulse decode.
  always_comb begin
    state_nx_s     = state_r;
    cnt_nx_s       = cnt_r;
    width_l_nx_s   = width_l_r;
    holdoff_l_nx_s = holdoff_l_r;
    trig_nx_s      = trigger_out_r;
    accept_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ifc.trigger_in && ifc.enable) begin
          accept_s       = 1'b1;
          width_l_nx_s   = ifc.width;
          holdoff_l_nx_s = ifc.holdoff;
          if (ifc.delay != {DLY_W{1'b0}}) begin
            state_nx_s = ST_DELAY;
            cnt_nx_s   = CW'(ifc.delay) - CW'(1);
          end else begin
            state_nx_s = ST_ACTIVE;
            cnt_nx_s   = pulse_len_m1(ifc.width);
            trig_nx_s  = 1'b1;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_DELAY: begin
        if (cnt_r == {CW{1'b0}}) begin
          state_nx_s = ST_ACTIVE;
          cnt_nx_s   = pulse_len_m1(width_l_r);
          trig_nx_s  = 1'b1;
        end else begin
          cnt_nx_s = cnt_r - CW'(1);
        end
      end
      ST_ACTIVE: begin
        if (cnt_r == {CW{1'b0}}) begin
          trig_nx_s = 1'b0;
          if (holdoff_l_r != {DLY_W{1'b0}}) begin
            state_nx_s = ST_HOLDOFF;
            cnt_nx_s   = CW'(holdoff_l_r) - CW'(1);
          end else begin
            state_nx_s = ST_IDLE;
          end
        end else begin
          cnt_nx_s = cnt_r - CW'(1);
        end
      end
      ST_HOLDOFF: begin
        if (cnt_r == {CW{1'b0}}) begin
          state_nx_s = ST_IDLE;
        end else begin
          cnt_nx_s = cnt_r - CW'(1);
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        trig_nx_s  = 1'b0;
      end
    endcase
  end

  // State, latched configuration, registered outputs and event counter.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_r       <= ST_IDLE;
      cnt_r         <= {CW{1'b0}};
      width_l_r     <= {PW_W{1'b0}};
      holdoff_l_r   <= {DLY_W{1'b0}};
      trigger_out_r <= 1'b0;
      busy_r        <= 1'b0;
      event_count_r <= {CNT_W{1'b0}};
    end else begin
      state_r       <= state_nx_s;
      cnt_r         <= cnt_nx_s;
      width_l_r     <= width_l_nx_s;
      holdoff_l_r   <= holdoff_l_nx_s;
      trigger_out_r <= trig_nx_s;
      busy_r        <= (state_nx_s != ST_IDLE);
      if (accept_s && (event_count_r != {CNT_W{1'b1}})) begin
        event_count_r <= event_count_r + CNT_W'(1);
      end else begin
        event_count_r <= event_count_r;
      end
    end
  end

  assign ifc.trigger_out = trigger_out_r;
  assign ifc.busy        = busy_r;
  assign ifc.event_count = event_count_r;

`ifdef CHDR_TRIG_MISS_COUNT_EN
  logic [CNT_W-1:0] miss_count_r;

  // Saturating count of triggers arriving while a pulse or holdoff is in flight.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      miss_count_r <= {CNT_W{1'b0}};
    end else if (ifc.trigger_in && (state_r != ST_IDLE) &&
                 (miss_count_r != {CNT_W{1'b1}})) begin
      miss_count_r <= miss_count_r + CNT_W'(1);
    end else begin
      miss_count_r <= miss_count_r;
    end
  end

  assign ifc.miss_count = miss_count_r;
`else
  assign ifc.miss_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_chdr_trigger_pulse_shaper.sv
// Directed, table-driven bench for chdr_trigger_pulse_shaper (narrow counters to reach saturation).
module tb_chdr_trigger_pulse_shaper;

  localparam int DLY_W = 16;
  localparam int PW_W  = 16;
  localparam int CNT_W = 4;

  logic clk;
  logic reset;
  logic clear;

  chdr_trigger_pulse_shaper_if #(.DLY_W(DLY_W), .PW_W(PW_W), .CNT_W(CNT_W)) tif ();

  chdr_trigger_pulse_shaper #(.DLY_W(DLY_W), .PW_W(PW_W), .CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .ifc   (tif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        trig;
    logic        en;
    logic [15:0] dly;
    logic [15:0] wid;
    logic [15:0] hold;
    logic        e_out;
    logic        e_busy;
    logic [3:0]  e_evt;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;
  logic [3:0] exp_miss;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Row i: inputs applied during a cycle, outputs expected in the following cycle.
  task automatic add(input logic trig, input logic en, input int d, input int w, input int h,
                     input logic eo, input logic eb, input int ee);
    vec_t v;
    v.trig = trig; v.en = en; v.dly = 16'(d); v.wid = 16'(w); v.hold = 16'(h);
    v.e_out = eo; v.e_busy = eb; v.e_evt = 4'(ee);
    vq.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic trig, input logic en, input int d, input int w, input int h);
    tif.trigger_in = trig;
    tif.enable     = en;
    tif.delay      = 16'(d);
    tif.width      = 16'(w);
    tif.holdoff    = 16'(h);
  endtask

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    drive(1'b0, 1'b1, 0, 1, 0);

    // Single-cycle pulse, no delay or holdoff
    add(1, 1, 0, 1, 0, 1, 1, 1);
    add(0, 1, 0, 1, 0, 0, 0, 1);
    // delay=3 width=4 holdoff=2, re-trigger accepted at T+10
    add(1, 1, 3, 4, 2, 0, 1, 2);
    add(0, 1, 3, 4, 2, 0, 1, 2);
    add(0, 1, 3, 4, 2, 0, 1, 2);
    add(0, 1, 3, 4, 2, 1, 1, 2);
    add(0, 1, 3, 4, 2, 1, 1, 2);
    add(0, 1, 3, 4, 2, 1, 1, 2);
    add(0, 1, 3, 4, 2, 1, 1, 2);
    add(0, 1, 3, 4, 2, 0, 1, 2);
    add(0, 1, 3, 4, 2, 0, 1, 2);
    add(0, 1, 3, 4, 2, 0, 0, 2);
    add(1, 1, 0, 1, 0, 1, 1, 3);
    add(0, 1, 0, 1, 0, 0, 0, 3);
    // width=0 gives one cycle; delay change mid-flight ignored
    add(1, 1, 3, 0, 0, 0, 1, 4);
    add(0, 1, 3, 0, 0, 0, 1, 4);
    add(0, 1, 10, 0, 0, 0, 1, 4);
    add(0, 1, 10, 0, 0, 1, 1, 4);
    add(0, 1, 10, 0, 0, 0, 0, 4);
    add(0, 1, 10, 0, 0, 0, 0, 4);
    // enable low ignores trigger; re-enabled trigger accepted
    add(1, 0, 0, 2, 0, 0, 0, 4);
    add(0, 0, 0, 2, 0, 0, 0, 4);
    add(1, 1, 0, 2, 0, 1, 1, 5);
    add(0, 1, 0, 2, 0, 1, 1, 5);
    add(0, 1, 0, 2, 0, 0, 0, 5);

`ifdef CHDR_TRIG_MISS_COUNT_EN
    exp_miss = 4'd1;
`else
    exp_miss = 4'd0;
`endif

    step();
    step();
    check("reset_out",  32'(tif.trigger_out), 32'd0);
    check("reset_busy", 32'(tif.busy),        32'd0);
    check("reset_evt",  32'(tif.event_count), 32'd0);
    check("reset_miss", 32'(tif.miss_count),  32'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].trig, vq[i].en, int'(vq[i].dly), int'(vq[i].wid), int'(vq[i].hold));
      step();
      check($sformatf("vec%0d_out", i),  32'(tif.trigger_out), 32'(vq[i].e_out));
      check($sformatf("vec%0d_busy", i), 32'(tif.busy),        32'(vq[i].e_busy));
      check($sformatf("vec%0d_evt", i),  32'(tif.event_count), 32'(vq[i].e_evt));
    end
    check("no_miss_in_table", 32'(tif.miss_count), 32'd0);

    // Clear wins over a coincident trigger
    clear = 1'b1;
    drive(1'b1, 1'b1, 0, 1, 0);
    step();
    clear = 1'b0;
    drive(1'b0, 1'b1, 0, 1, 0);
    check("clr_prio_busy", 32'(tif.busy),        32'd0);
    check("clr_prio_evt",  32'(tif.event_count), 32'd0);
    step();
    check("clr_prio_out",  32'(tif.trigger_out), 32'd0);

    // Trigger on the last holdoff cycle (T+9) is dropped
    drive(1'b1, 1'b1, 3, 4, 2);
    step();
    drive(1'b0, 1'b1, 3, 4, 2);
    repeat (8) step();
    check("t3_busy_t9", 32'(tif.busy), 32'd1);
    drive(1'b1, 1'b1, 3, 4, 2);
    step();
    check("t3_busy_t10", 32'(tif.busy),        32'd0);
    check("t3_evt",      32'(tif.event_count), 32'd1);
    check("t3_miss",     32'(tif.miss_count),  32'(exp_miss));
    step();
    drive(1'b0, 1'b1, 3, 4, 2);
    check("t3_reaccept_busy", 32'(tif.busy),        32'd1);
    check("t3_reaccept_evt",  32'(tif.event_count), 32'd2);
    repeat (12) step();

    // Clear mid-pulse at T+5
    clear = 1'b1;
    step();
    clear = 1'b0;
    drive(1'b1, 1'b1, 3, 4, 2);
    step();
    drive(1'b0, 1'b1, 3, 4, 2);
    repeat (4) step();
    check("t6_out_t5", 32'(tif.trigger_out), 32'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t6_out_t6",  32'(tif.trigger_out), 32'd0);
    check("t6_busy_t6", 32'(tif.busy),        32'd0);
    check("t6_evt",     32'(tif.event_count), 32'd0);
    check("t6_miss",    32'(tif.miss_count),  32'd0);

    // Event counter saturation
    for (int k = 0; k < 14; k++) begin
      drive(1'b1, 1'b1, 0, 1, 0);
      step();
      drive(1'b0, 1'b1, 0, 1, 0);
      step();
    end
    check("sat_evt14", 32'(tif.event_count), 32'd14);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 0, 1, 0);
      step();
      drive(1'b0, 1'b1, 0, 1, 0);
      step();
      check($sformatf("sat_evt_k%0d", k), 32'(tif.event_count), 32'd15);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
